mdio_peripheral_param: RTL and testbench

MDIO_PERIPHERAL_PARAM -- requirements
Module: mdio_peripheral_param

---
 rtl/mdio_peripheral_param.sv | 223 ++++++++++++++++++++++
 tb/tb_mdio_peripheral_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral_param.sv
// mdio_peripheral_param: Clause-22 style MDIO peripheral with parameterised register/data widths.
// Ports:
//   MDC        - management clock, all logic on posedge
//   RESET      - asynchronous active-low reset
//   MDIO_OUT   - serial bit from controller, valid when MDIO_OE=1
//   MDIO_OE    - controller is driving the line
//   RD_DATA    - register file read data for ADDR
//   ADDR       - register address of the current frame
//   WR_DATA    - write data, held until the next accepted write
//   WR_STB     - one-cycle write strobe
//   MDIO_DONE  - one-cycle frame-complete pulse
//   MDIO_IN    - serial bit to controller
//   PERIPH_OE  - peripheral drives the line
module mdio_peripheral_param #(
    parameter int         DATA_W   = 16,
    parameter int         REG_AW   = 5,
    parameter logic [4:0] PHY_ADDR = 5'h01,
    parameter int         PRE_LEN  = 32,
    parameter bit         BCAST_EN = 1'b1
) (
    input  logic              MDC,
    input  logic              RESET,
    input  logic              MDIO_OUT,
    input  logic              MDIO_OE,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic [REG_AW-1:0] ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_STB,
    output logic              MDIO_DONE,
    output logic              MDIO_IN,
    output logic              PERIPH_OE
);
    // Shared shift register is wide enough for PHYAD, REGAD and data fields
    localparam int SW = (DATA_W > REG_AW) ? ((DATA_W > 5) ? DATA_W : 5) : ((REG_AW > 5) ? REG_AW : 5);
    localparam int BW = $clog2(SW) + 1;
    localparam int PW = $clog2(PRE_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [SW-1:0]     sh_q, sh_d, shifted;
    logic              rd_q, rd_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              wstb_q, wstb_d;
    logic              done_q, done_d;
    logic              min_q, min_d;
    logic              poe_q, poe_d;
    logic              abort;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        wstb_d  = 1'b0;
        done_d  = 1'b0;
        min_d   = min_q;
        poe_d   = poe_q;
        abort   = 1'b0;
        shifted = {sh_q[SW-2:0], MDIO_OUT};
        case (state_q)
            S_IDLE: begin
                if (MDIO_OE) begin
                    if (MDIO_OUT) begin
                        pre_d = (pre_q == PW'(PRE_LEN)) ? pre_q : pre_q + 1'b1;
                    end else if (pre_q == PW'(PRE_LEN)) begin
                        state_d = S_ST;
                        pre_d   = '0;
                    end else begin
                        pre_d = '0;
                    end
                end
            end
            S_ST: begin
                if (!MDIO_OE || !MDIO_OUT) begin
                    abort = 1'b1;
                end else begin
                    state_d = S_OP;
                    bit_d   = '0;
                end
            end
            S_OP: begin
                if (!MDIO_OE) begin
                    abort = 1'b1;
                end else if (bit_q == '0) begin
                    sh_d  = shifted;
                    bit_d = 1'b1;
                end else if (sh_q[0] == MDIO_OUT) begin
                    abort = 1'b1;
                end else begin
                    // 10 is read, 01 is write: first OP bit alone tells them apart
                    rd_d    = sh_q[0];
                    state_d = S_PHYAD;
                    bit_d   = '0;
                end
            end
            S_PHYAD: begin
                if (!MDIO_OE) begin
                    abort = 1'b1;
                end else begin
                    sh_d  = shifted;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(4)) begin
                        if (shifted[4:0] == PHY_ADDR || (BCAST_EN && !rd_q && shifted[4:0] == 5'd0)) begin
                            state_d = S_REGAD;
                            bit_d   = '0;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
            end
            S_REGAD: begin
                if (!MDIO_OE) begin
                    abort = 1'b1;
                end else begin
                    sh_d  = shifted;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(REG_AW - 1)) begin
                        addr_d  = shifted[REG_AW-1:0];
                        state_d = S_TA;
                        bit_d   = '0;
                    end
                end
            end
            S_TA: begin
                if (rd_q) begin
                    // Controller has released the line; drive the second TA bit low
                    sh_d    = SW'(RD_DATA);
                    poe_d   = 1'b1;
                    min_d   = 1'b0;
                    state_d = S_RDATA;
                    bit_d   = '0;
                end else if (!MDIO_OE || MDIO_OUT != (bit_q == '0)) begin
                    abort = 1'b1;
                end else if (bit_q == '0) begin
                    bit_d = 1'b1;
                end else begin
                    state_d = S_WDATA;
                    bit_d   = '0;
                end
            end
            S_WDATA: begin
                if (!MDIO_OE) begin
                    abort = 1'b1;
                end else begin
                    sh_d  = shifted;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        wdat_d  = shifted[DATA_W-1:0];
                        wstb_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RDATA: begin
                min_d = sh_q[DATA_W-1];
                sh_d  = sh_q << 1;
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == BW'(DATA_W - 1)) ? S_DONE : S_RDATA;
            end
            S_DONE: begin
                // Reads finish here; writes already pulsed on their last data edge
                done_d  = rd_q;
                poe_d   = 1'b0;
                min_d   = 1'b0;
                pre_d   = PW'(MDIO_OE && MDIO_OUT);
                state_d = S_IDLE;
            end
            default: abort = 1'b1;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            pre_d   = '0;
            poe_d   = 1'b0;
            min_d   = 1'b0;
        end
    end

    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            wstb_q  <= 1'b0;
            done_q  <= 1'b0;
            min_q   <= 1'b0;
            poe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            wstb_q  <= wstb_d;
            done_q  <= done_d;
            min_q   <= min_d;
            poe_q   <= poe_d;
        end
    end

    assign ADDR      = addr_q;
    assign WR_DATA   = wdat_q;
    assign WR_STB    = wstb_q;
    assign MDIO_DONE = done_q;
    assign MDIO_IN   = min_q;
    assign PERIPH_OE = poe_q;
endmodule

// File: tb/tb_mdio_peripheral_param.sv
// tb_mdio_peripheral_param: scoreboard-driven bench for the MDIO peripheral.
module tb_mdio_peripheral_param;
    logic        MDC = 1'b0;
    logic        RESET = 1'b0;
    logic        MDIO_OUT = 1'b0;
    logic        MDIO_OE = 1'b0;
    logic [15:0] RD_DATA = 16'h0;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB, MDIO_DONE, MDIO_IN, PERIPH_OE;

    int          checks = 0, passed = 0;
    int          n_stb = 0, n_done = 0, n_poe = 0, rd_len = 0;
    logic        rd_active = 1'b0;
    logic [16:0] rd_bits = '0;
    logic [20:0] exp_wr[$];
    logic [16:0] exp_rd[$];
    logic [15:0] last_wd = 16'h0;

    always #5 MDC = ~MDC;

    mdio_peripheral_param dut (
        .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA),
        .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB), .MDIO_DONE(MDIO_DONE),
        .MDIO_IN(MDIO_IN), .PERIPH_OE(PERIPH_OE)
    );

    // One MDC bit: observe outputs of the previous edge, then drive the next bit
    task automatic step(input logic oe, input logic b);
        logic [20:0] ew;
        logic [16:0] er;
        @(negedge MDC);
        if (WR_STB) begin
            n_stb++;
            checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_scoreboard: unexpected strobe addr=%h data=%h, required no strobe", ADDR, WR_DATA);
            end else begin
                ew = exp_wr.pop_front();
                if ({ADDR, WR_DATA} !== ew) $display("FAIL wr_scoreboard: got addr=%h data=%h, required addr=%h data=%h", ADDR, WR_DATA, ew[20:16], ew[15:0]);
                else passed++;
            end
        end
        if (MDIO_DONE) n_done++;
        if (PERIPH_OE) begin
            n_poe++;
            rd_bits = {rd_bits[15:0], MDIO_IN};
            rd_len++;
            rd_active = 1'b1;
        end else if (rd_active) begin
            rd_active = 1'b0;
            checks++;
            if (exp_rd.size() == 0) begin
                $display("FAIL rd_scoreboard: unexpected read drive bits=%h len=%0d, required none", rd_bits, rd_len);
            end else begin
                er = exp_rd.pop_front();
                if (rd_len != 17 || rd_bits !== er) $display("FAIL rd_scoreboard: got bits=%h len=%0d, required bits=%h len=17", rd_bits, rd_len, er);
                else passed++;
            end
            rd_len = 0;
            rd_bits = '0;
        end
        MDIO_OE = oe;
        MDIO_OUT = b;
    endtask

    task automatic send(input logic [31:0] v, input int n, input logic oe);
        for (int i = n - 1; i >= 0; i--) step(oe, v[i]);
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] data, input int oe_bits, input int idle);
        for (int i = 0; i < pre; i++) step(1'b1, 1'b1);
        send(32'b01, 2, 1'b1);
        send({30'd0, op}, 2, 1'b1);
        send({27'd0, phy}, 5, 1'b1);
        send({27'd0, regad}, 5, 1'b1);
        if (op == 2'b10) begin
            for (int i = 0; i < 18; i++) step(1'b0, 1'b0);
        end else begin
            send(32'b10, 2, 1'b1);
            for (int i = 15; i >= 0; i--) step((15 - i) < oe_bits, data[i]);
        end
        for (int i = 0; i < idle; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ADDR !== 5'h0) $display("FAIL reset_addr: got %h, required 00", ADDR); else passed++;
        checks++;
        if (WR_DATA !== 16'h0) $display("FAIL reset_wr_data: got %h, required 0000", WR_DATA); else passed++;
        checks++;
        if ({WR_STB, MDIO_DONE, MDIO_IN, PERIPH_OE} !== 4'b0) $display("FAIL reset_ctrl: got %b, required 0000", {WR_STB, MDIO_DONE, MDIO_IN, PERIPH_OE}); else passed++;
        @(negedge MDC);
        RESET = 1'b1;
    endtask

    task automatic test_write();
        int s0 = n_stb, d0 = n_done;
        exp_wr.push_back({5'h10, 16'hABCD});
        last_wd = 16'hABCD;
        frame(32, 2'b01, 5'h01, 5'h10, 16'hABCD, 16, 4);
        checks++;
        if (n_stb - s0 != 1) $display("FAIL write_stb_count: got %0d, required 1", n_stb - s0); else passed++;
        checks++;
        if (n_done - d0 != 1) $display("FAIL write_done_count: got %0d, required 1", n_done - d0); else passed++;
        checks++;
        if (WR_DATA !== 16'hABCD) $display("FAIL write_hold: got %h, required abcd", WR_DATA); else passed++;
    endtask

    task automatic test_read(input logic [4:0] regad, input logic [15:0] val);
        int s0 = n_stb, d0 = n_done, p0 = n_poe;
        RD_DATA = val;
        exp_rd.push_back({1'b0, val});
        frame(32, 2'b10, 5'h01, regad, 16'h0, 0, 4);
        checks++;
        if (n_poe - p0 != 17) $display("FAIL read_oe_cycles: got %0d, required 17", n_poe - p0); else passed++;
        checks++;
        if (n_done - d0 != 1) $display("FAIL read_done_count: got %0d, required 1", n_done - d0); else passed++;
        checks++;
        if (n_stb != s0) $display("FAIL read_no_stb: got %0d, required 0", n_stb - s0); else passed++;
        checks++;
        if (ADDR !== regad) $display("FAIL read_addr: got %h, required %h", ADDR, regad); else passed++;
    endtask

    task automatic test_preamble();
        int s0 = n_stb;
        frame(31, 2'b01, 5'h01, 5'h05, 16'h1357, 16, 4);
        checks++;
        if (n_stb != s0) $display("FAIL short_preamble: got %0d strobes, required 0", n_stb - s0); else passed++;
        exp_wr.push_back({5'h05, 16'h1357});
        last_wd = 16'h1357;
        frame(32, 2'b01, 5'h01, 5'h05, 16'h1357, 16, 4);
        checks++;
        if (n_stb - s0 != 1) $display("FAIL full_preamble: got %0d strobes, required 1", n_stb - s0); else passed++;
    endtask

    task automatic test_bad_phy();
        int s0 = n_stb, d0 = n_done, p0 = n_poe;
        frame(32, 2'b01, 5'h02, 5'h06, 16'hABCD, 16, 4);
        RD_DATA = 16'hFFFF;
        frame(32, 2'b10, 5'h00, 5'h10, 16'h0, 0, 4);
        checks++;
        if (n_stb != s0) $display("FAIL bad_phy_stb: got %0d, required 0", n_stb - s0); else passed++;
        checks++;
        if (n_done != d0) $display("FAIL bad_phy_done: got %0d, required 0", n_done - d0); else passed++;
        checks++;
        if (n_poe != p0) $display("FAIL bad_phy_oe: got %0d cycles, required 0", n_poe - p0); else passed++;
        checks++;
        if (WR_DATA !== last_wd) $display("FAIL bad_phy_hold: got %h, required %h", WR_DATA, last_wd); else passed++;
        exp_wr.push_back({5'h0A, 16'h6B2E});
        last_wd = 16'h6B2E;
        frame(32, 2'b01, 5'h00, 5'h0A, 16'h6B2E, 16, 4);
        checks++;
        if (n_stb - s0 != 1) $display("FAIL bcast_write: got %0d strobes, required 1", n_stb - s0); else passed++;
    endtask

    task automatic test_oe_drop();
        int s0 = n_stb, d0 = n_done;
        frame(32, 2'b01, 5'h01, 5'h07, 16'h9999, 8, 4);
        checks++;
        if (n_stb != s0 || n_done != d0) $display("FAIL oe_drop: got stb=%0d done=%0d, required 0 0", n_stb - s0, n_done - d0); else passed++;
        checks++;
        if (WR_DATA !== last_wd) $display("FAIL oe_drop_hold: got %h, required %h", WR_DATA, last_wd); else passed++;
        exp_wr.push_back({5'h03, 16'hFEED});
        last_wd = 16'hFEED;
        frame(32, 2'b01, 5'h01, 5'h03, 16'hFEED, 16, 4);
        checks++;
        if (n_stb - s0 != 1) $display("FAIL oe_drop_recover: got %0d strobes, required 1", n_stb - s0); else passed++;
    endtask

    task automatic test_back_to_back();
        int s0 = n_stb, d0 = n_done;
        exp_wr.push_back({5'h11, 16'h1111});
        exp_wr.push_back({5'h1E, 16'h2222});
        last_wd = 16'h2222;
        frame(32, 2'b01, 5'h01, 5'h11, 16'h1111, 16, 0);
        frame(32, 2'b01, 5'h01, 5'h1E, 16'h2222, 16, 4);
        checks++;
        if (n_stb - s0 != 2) $display("FAIL b2b_stb: got %0d, required 2", n_stb - s0); else passed++;
        checks++;
        if (n_done - d0 != 2) $display("FAIL b2b_done: got %0d, required 2", n_done - d0); else passed++;
    endtask

    task automatic test_reset_mid();
        int s0 = n_stb, d0 = n_done;
        RD_DATA = 16'h5A3C;
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
        send(32'b01, 2, 1'b1);
        send(32'b10, 2, 1'b1);
        send(32'h01, 5, 1'b1);
        send(32'h07, 5, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        @(posedge MDC);
        #2;
        checks++;
        if (PERIPH_OE !== 1'b1) $display("FAIL mid_read_oe: got %b, required 1", PERIPH_OE); else passed++;
        RESET = 1'b0;
        #1;
        checks++;
        if ({ADDR, WR_DATA, WR_STB, MDIO_DONE, MDIO_IN, PERIPH_OE} !== 25'd0)
            $display("FAIL mid_reset_outputs: got addr=%h data=%h ctrl=%b, required all zero", ADDR, WR_DATA, {WR_STB, MDIO_DONE, MDIO_IN, PERIPH_OE});
        else passed++;
        rd_active = 1'b0;
        rd_len = 0;
        rd_bits = '0;
        @(negedge MDC);
        RESET = 1'b1;
        checks++;
        if (n_done != d0) $display("FAIL mid_reset_done: got %0d, required 0", n_done - d0); else passed++;
        frame(31, 2'b01, 5'h01, 5'h09, 16'h0F0F, 16, 4);
        checks++;
        if (n_stb != s0) $display("FAIL post_reset_short: got %0d strobes, required 0", n_stb - s0); else passed++;
        exp_wr.push_back({5'h09, 16'h0F0F});
        frame(32, 2'b01, 5'h01, 5'h09, 16'h0F0F, 16, 4);
        checks++;
        if (n_stb - s0 != 1) $display("FAIL post_reset_full: got %0d strobes, required 1", n_stb - s0); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(5'h10, 16'h1234);
        test_preamble();
        test_read(5'h07, 16'hA5C3);
        test_bad_phy();
        test_oe_drop();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) $display("FAIL scoreboard_drain: got wr=%0d rd=%0d pending, required 0 0", exp_wr.size(), exp_rd.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
